// File: rtl/stack_pkg.sv
// Shared stack types: SP control codes, sequencer states and default stack bounds.
// Also imported by the SP register so both sides agree on the control encoding.
package stack_pkg;

  localparam int          ADDR_W_DEFAULT      = 20;
  localparam logic [19:0] STACK_TOP_DEFAULT   = 20'hFFFFF;
  localparam logic [19:0] STACK_LIMIT_DEFAULT = 20'hFF000;

  typedef enum logic [2:0] {
    SP_HOLD = 3'b000,
    SP_INC2 = 3'b001,
    SP_DEC2 = 3'b010,
    SP_INC1 = 3'b011,
    SP_DEC1 = 3'b100
  } sp_ctrl_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_UPD,
    ST_RSP
  } sau_state_t;

  // A push grows the stack downwards, a pop shrinks it; 32-bit moves by two words.
  function automatic sp_ctrl_t sp_code(input logic pop, input logic wide);
    case ({pop, wide})
      2'b00:   return SP_DEC1;
      2'b01:   return SP_DEC2;
      2'b10:   return SP_INC1;
      default: return SP_INC2;
    endcase
  endfunction

endpackage

// File: rtl/stack_access_unit_if.sv
// Command/response and word-memory handshake of the stack access unit.
// master = execute stage plus memory side, slave = the stack access unit.
interface stack_access_unit_if #(
  parameter int ADDR_W = 20
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic              cmd_size;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output cmd_valid, cmd_op, cmd_size, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_size, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

endinterface

// File: rtl/stack_access_unit.sv
// Push/pop sequencer for the 16-bit word stack: splits 32-bit operands, drives memory, pulses SP control.
// Define STACK_GUARD_EN to reject pops past STACK_TOP and pushes below STACK_LIMIT with err_o.
module stack_access_unit
  import stack_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] STACK_TOP   = STACK_TOP_DEFAULT,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
  input  logic                clk,
  input  logic                Rst,
  stack_access_unit_if.slave  bus,
  input  logic [31:0]         sp_i,
  output sp_ctrl_t            sp_ctrl_o,
  output logic                err_o
);

`ifdef STACK_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  sau_state_t        state;
  logic              op_q;
  logic              size_q;
  logic [15:0]       wdata_lo_q;
  logic [ADDR_W-1:0] sp_q;
  logic [31:0]       rdata_q;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  sp_ctrl_t          sp_ctrl_q;
  logic              err_q;

  // Word addresses wrap modulo the memory size, so only the low SP bits matter.
  logic [ADDR_W-1:0] sp_low;
  logic              unused_sp_hi;
  logic [ADDR_W-1:0] first_addr_c;
  logic [15:0]       first_wdata_c;
  logic [ADDR_W-1:0] second_addr_c;

  assign sp_low        = sp_i[ADDR_W-1:0];
  assign unused_sp_hi  = ^sp_i[31:ADDR_W];
  assign first_addr_c  = bus.cmd_op ? sp_low + ONE : sp_low;
  assign first_wdata_c = bus.cmd_op   ? 16'h0000 :
                         bus.cmd_size ? bus.cmd_wdata[31:16] : bus.cmd_wdata[15:0];
  assign second_addr_c = op_q ? sp_q + TWO : sp_q - ONE;

  // One extra bit keeps the bound comparisons free of wrap-around.
  logic [ADDR_W:0] sp_x;
  logic [ADDR_W:0] size_x;
  logic            underflow_c;
  logic            overflow_c;
  logic            guard_hit;

  assign sp_x        = {1'b0, sp_low};
  assign size_x      = {{ADDR_W{1'b0}}, bus.cmd_size};
  assign underflow_c = bus.cmd_op  && ((sp_x + size_x + (ADDR_W+1)'(1)) > {1'b0, STACK_TOP});
  assign overflow_c  = !bus.cmd_op && (sp_x < ({1'b0, STACK_LIMIT} + size_x));
  assign guard_hit   = GUARD_EN && (underflow_c || overflow_c);

  assign bus.cmd_ready = (state == ST_IDLE) && !Rst;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign sp_ctrl_o     = sp_ctrl_q;
  assign err_o         = err_q;

  always_ff @(posedge clk) begin
    if (Rst) begin
      state       <= ST_IDLE;
      op_q        <= 1'b0;
      size_q      <= 1'b0;
      wdata_lo_q  <= '0;
      sp_q        <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      sp_ctrl_q   <= SP_HOLD;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      sp_ctrl_q   <= SP_HOLD;
      err_q       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            size_q      <= bus.cmd_size;
            wdata_lo_q  <= bus.cmd_wdata[15:0];
            sp_q        <= sp_low;
            rdata_q     <= '0;
            rsp_rdata_q <= '0;
            if (guard_hit) begin
              state       <= ST_RSP;
              rsp_valid_q <= 1'b1;
              err_q       <= 1'b1;
            end else begin
              state       <= ST_ACC0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= !bus.cmd_op;
              mem_addr_q  <= first_addr_c;
              mem_wdata_q <= first_wdata_c;
            end
          end
        end

        // A 32-bit push writes the high word first at SP; a pop reads the low word first.
        ST_ACC0: begin
          if (bus.mem_ack) begin
            if (op_q) rdata_q[15:0] <= bus.mem_rdata;
            if (size_q) begin
              state       <= ST_ACC1;
              mem_addr_q  <= second_addr_c;
              mem_wdata_q <= op_q ? 16'h0000 : wdata_lo_q;
            end else begin
              state     <= ST_UPD;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              sp_ctrl_q <= sp_code(op_q, size_q);
            end
          end
        end

        ST_ACC1: begin
          if (bus.mem_ack) begin
            if (op_q) rdata_q[31:16] <= bus.mem_rdata;
            state     <= ST_UPD;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            sp_ctrl_q <= sp_code(op_q, size_q);
          end
        end

        ST_UPD: begin
          state       <= ST_RSP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rdata_q;
        end

        ST_RSP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_access_unit.sv
// Directed bench for stack_access_unit: vector table plus reset-abort sequence, against a word-memory model.
`timescale 1ns/1ps
module tb_stack_access_unit;

  localparam int ADDR_W = 20;

  logic        clk = 1'b0;
  logic        Rst;
  logic [31:0] sp_i;
  logic [2:0]  sp_ctrl_o;
  logic        err_o;

  stack_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  stack_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .bus      (bus),
    .sp_i     (sp_i),
    .sp_ctrl_o(sp_ctrl_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } acc_t;

  typedef struct {
    logic        op;
    logic        size;
    logic [31:0] wdata;
    logic [31:0] sp;
    int          delay;
    bit          poke;
    int          nacc;
    logic [19:0] a0;
    logic [15:0] d0;
    logic [19:0] a1;
    logic [15:0] d1;
    logic [31:0] rdata;
    logic [2:0]  code;
    int          pulses;
    int          upd;
    int          rsp;
    int          req;
    int          err;
  } vec_t;

  logic [15:0] mem [logic [ADDR_W-1:0]];
  acc_t        acc_log [$];
  int          ack_delay = 0;
  int          wait_cnt  = 0;

  vec_t vecs [10];
  int   nvec = 0;
  int   total = 0;
  int   bad = 0;

  int          log_base;
  int          obs_req, obs_pulses, obs_upd, obs_rsp_cnt, obs_rsp_cyc, obs_err;
  logic [2:0]  obs_code;
  logic [31:0] obs_rdata, obs_hold;
  logic        obs_ready_busy;

  // Memory model: acks after ack_delay wait cycles, a fresh access follows every completed one.
  always @(negedge clk) begin
    if (bus.mem_req && !Rst) begin
      if (bus.mem_ack) wait_cnt = 0;
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 16'h0000;
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0000;
      wait_cnt      = 0;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack && !Rst) begin
      acc_log.push_back('{bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : bus.mem_rdata});
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input vec_t v);
    vecs[nvec] = v;
    nvec++;
  endtask

  // Issues one command, then watches 20 cycles; cycle 1 is the first cycle after the accept edge.
  task automatic applyStimulus(input logic op, input logic size, input logic [31:0] wdata,
                               input logic [31:0] sp, input int delay, input bit poke);
    ack_delay      = delay;
    log_base       = acc_log.size();
    obs_req        = 0;
    obs_pulses     = 0;
    obs_upd        = 0;
    obs_code       = 3'b000;
    obs_rsp_cnt    = 0;
    obs_rsp_cyc    = 0;
    obs_rdata      = 32'h0;
    obs_err        = 0;
    obs_ready_busy = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_size  = size;
    bus.cmd_wdata = wdata;
    sp_i          = sp;
    @(negedge clk);
    bus.cmd_valid = poke;
    bus.cmd_op    = 1'b0;
    bus.cmd_size  = 1'b0;
    bus.cmd_wdata = 32'h0BAD0BAD;
    sp_i          = 32'h0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 2) obs_ready_busy = bus.cmd_ready;
      if (cyc == 4) bus.cmd_valid = 1'b0;
      if (bus.mem_req) obs_req++;
      if (err_o) obs_err++;
      if (sp_ctrl_o != 3'b000) begin
        obs_pulses++;
        if (obs_pulses == 1) begin
          obs_upd  = cyc;
          obs_code = sp_ctrl_o;
        end
      end
      if (bus.rsp_valid) begin
        obs_rsp_cnt++;
        if (obs_rsp_cnt == 1) begin
          obs_rsp_cyc = cyc;
          obs_rdata   = bus.rsp_rdata;
        end
      end
      @(negedge clk);
    end
    obs_hold = bus.rsp_rdata;
  endtask

  initial begin
    int   rst_pulses;
    int   rst_rsp;
    int   base;
    vec_t v;

    Rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_size  = 1'b0;
    bus.cmd_wdata = 32'h0;
    sp_i          = 32'h000FFFFF;

    addVec('{1'b0, 1'b0, 32'hDEADBEEF, 32'h000FFFFF, 0, 1'b0, 1, 20'hFFFFF, 16'hBEEF, 20'h0, 16'h0, 32'h0, 3'b100, 1, 2, 3, 1, 0});
    addVec('{1'b0, 1'b1, 32'h12345678, 32'h000FFFFF, 0, 1'b0, 2, 20'hFFFFF, 16'h1234, 20'hFFFFE, 16'h5678, 32'h0, 3'b010, 1, 3, 4, 2, 0});
    addVec('{1'b1, 1'b1, 32'h0, 32'h000FFFFD, 0, 1'b0, 2, 20'hFFFFE, 16'h0, 20'hFFFFF, 16'h0, 32'h12345678, 3'b001, 1, 3, 4, 2, 0});
    addVec('{1'b1, 1'b0, 32'h0, 32'h000FFFFE, 3, 1'b1, 1, 20'hFFFFF, 16'h0, 20'h0, 16'h0, 32'h00001234, 3'b011, 1, 5, 6, 4, 0});
`ifdef STACK_GUARD_EN
    addVec('{1'b1, 1'b0, 32'h0, 32'h000FFFFF, 0, 1'b0, 0, 20'h0, 16'h0, 20'h0, 16'h0, 32'h0, 3'b000, 0, 0, 1, 0, 1});
    addVec('{1'b0, 1'b0, 32'h00004444, 32'h000FEFFF, 0, 1'b0, 0, 20'h0, 16'h0, 20'h0, 16'h0, 32'h0, 3'b000, 0, 0, 1, 0, 1});
    addVec('{1'b1, 1'b1, 32'h0, 32'h000FFFFE, 0, 1'b0, 0, 20'h0, 16'h0, 20'h0, 16'h0, 32'h0, 3'b000, 0, 0, 1, 0, 1});
    addVec('{1'b0, 1'b1, 32'h11112222, 32'h000FF002, 0, 1'b0, 2, 20'hFF002, 16'h1111, 20'hFF001, 16'h2222, 32'h0, 3'b010, 1, 3, 4, 2, 0});
`else
    addVec('{1'b0, 1'b1, 32'hCAFEF00D, 32'h00000000, 1, 1'b0, 2, 20'h00000, 16'hCAFE, 20'hFFFFF, 16'hF00D, 32'h0, 3'b010, 1, 5, 6, 4, 0});
    addVec('{1'b1, 1'b0, 32'h0, 32'h000FFFFF, 0, 1'b0, 1, 20'h00000, 16'h0, 20'h0, 16'h0, 32'h0000CAFE, 3'b011, 1, 2, 3, 1, 0});
    addVec('{1'b0, 1'b1, 32'hA5A55A5A, 32'hABC00100, 0, 1'b0, 2, 20'h00100, 16'hA5A5, 20'h000FF, 16'h5A5A, 32'h0, 3'b010, 1, 3, 4, 2, 0});
    addVec('{1'b1, 1'b1, 32'h0, 32'h000000FE, 2, 1'b0, 2, 20'h000FF, 16'h0, 20'h00100, 16'h0, 32'hA5A55A5A, 3'b001, 1, 7, 8, 6, 0});
`endif

    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    checkOutput("reset_mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("reset_sp_ctrl", 32'(sp_ctrl_o), 32'h0);
    checkOutput("reset_err", 32'(err_o), 32'h0);
    Rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 32'(bus.cmd_ready), 32'h1);

    for (int i = 0; i < nvec; i++) begin
      v = vecs[i];
      applyStimulus(v.op, v.size, v.wdata, v.sp, v.delay, v.poke);
      checkOutput($sformatf("v%0d_acc_count", i), 32'(acc_log.size() - log_base), 32'(v.nacc));
      for (int k = 0; k < v.nacc; k++) begin
        if (log_base + k < acc_log.size()) begin
          checkOutput($sformatf("v%0d_acc%0d_addr", i, k), 32'(acc_log[log_base+k].addr), 32'(k == 0 ? v.a0 : v.a1));
          checkOutput($sformatf("v%0d_acc%0d_we", i, k), 32'(acc_log[log_base+k].we), 32'(!v.op));
          if (!v.op)
            checkOutput($sformatf("v%0d_acc%0d_wdata", i, k), 32'(acc_log[log_base+k].data), 32'(k == 0 ? v.d0 : v.d1));
        end
      end
      checkOutput($sformatf("v%0d_sp_code", i), 32'(obs_code), 32'(v.code));
      checkOutput($sformatf("v%0d_sp_pulses", i), 32'(obs_pulses), 32'(v.pulses));
      checkOutput($sformatf("v%0d_upd_cycle", i), 32'(obs_upd), 32'(v.upd));
      checkOutput($sformatf("v%0d_rsp_cycle", i), 32'(obs_rsp_cyc), 32'(v.rsp));
      checkOutput($sformatf("v%0d_rsp_count", i), 32'(obs_rsp_cnt), 32'h1);
      checkOutput($sformatf("v%0d_rsp_rdata", i), obs_rdata, v.rdata);
      checkOutput($sformatf("v%0d_rdata_hold", i), obs_hold, v.rdata);
      checkOutput($sformatf("v%0d_req_cycles", i), 32'(obs_req), 32'(v.req));
      checkOutput($sformatf("v%0d_err_cycles", i), 32'(obs_err), 32'(v.err));
      if (v.poke)
        checkOutput($sformatf("v%0d_busy_ready", i), 32'(obs_ready_busy), 32'h0);
    end

    // Reset while the low word of a 32-bit push is pending.
    ack_delay = 2;
    base      = acc_log.size();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_size  = 1'b1;
    bus.cmd_wdata = 32'h77778888;
    sp_i          = 32'h000FFFF0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_seq_in_acc1_addr", 32'(bus.mem_addr), 32'h000FFFEF);
    checkOutput("rst_seq_in_acc1_req", 32'(bus.mem_req), 32'h1);
    Rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_seq_ready_low", 32'(bus.cmd_ready), 32'h0);
    checkOutput("rst_seq_req_low", 32'(bus.mem_req), 32'h0);
    Rst        = 1'b0;
    rst_pulses = 0;
    rst_rsp    = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (cyc == 0) checkOutput("rst_seq_ready_idle", 32'(bus.cmd_ready), 32'h1);
      if (sp_ctrl_o != 3'b000) rst_pulses++;
      if (bus.rsp_valid) rst_rsp++;
    end
    checkOutput("rst_seq_sp_pulses", 32'(rst_pulses), 32'h0);
    checkOutput("rst_seq_rsp_count", 32'(rst_rsp), 32'h0);
    checkOutput("rst_seq_acc_count", 32'(acc_log.size() - base), 32'h1);
    checkOutput("rst_seq_hi_word_kept", 32'(mem.exists(20'hFFFF0) ? mem[20'hFFFF0] : 16'h0), 32'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_access_unit.md
Name: stack_access_unit

Overview:
- Sequencer for 16-bit word stack memory on push/pop commands from the execute/memory stage (register push/pop, CALL/RET/INT PC and flags save).
- Splits 32-bit operands into two word accesses and drives the memory handshake.
- Emits the one-cycle 3-bit control code that moves the stack pointer register.
- Consumes the current SP value; the SP register itself is outside this block.

Parameters:
- ADDR_W, 20, data-memory word-address width; mem_addr = (sp_i ± offset)[ADDR_W-1:0].
- STACK_TOP, 20'hFFFFF, SP value when the stack is empty (matches SP reset value 1048575).
- STACK_LIMIT, 20'hFF000, lowest legal slot address (guard feature only).

Ports:
- clk  in  1  clock, rising edge.
- Rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0=push, 1=pop.
- cmd_size  in  1  0=16-bit, 1=32-bit.
- cmd_wdata  in  32  push data; for 16-bit, only [15:0] is used.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  pop data, zero-extended for 16-bit; 0 for push.
- sp_i  in  32  current stack pointer.
- sp_ctrl_o  out  3  SP control: 000 hold, 001 +2, 010 -2, 011 +1, 100 -1.
- mem_req  out  1  memory access request.
- mem_we  out  1  1=write.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid with mem_ack.
- mem_ack  in  1  access complete; may arrive in the same cycle as mem_req.
- err_o  out  1  overflow/underflow pulse (guard feature only; otherwise tied 0).

Behaviour:
- Reset values: cmd_ready=0 during Rst, then 1 in IDLE. All other outputs are 0, including sp_ctrl_o=000.
- Reset during an operation: return to IDLE on the next edge, no SP pulse, no response. Words already written stay in memory.
- States: IDLE, ACC0, ACC1, UPD, RSP.
- IDLE:
  - On cmd_valid & cmd_ready, latch op, size, wdata and sp_i (as sp_q), then go to ACC0.
  - sp_i is never sampled after acceptance.
- Push16: ACC0 writes wdata[15:0] at sp_q.
- Push32:
  - ACC0 writes wdata[31:16] at sp_q.
  - ACC1 writes wdata[15:0] at sp_q-1.
- Pop16: ACC0 reads sp_q+1 into rdata[15:0].
- Pop32:
  - ACC0 reads sp_q+1 into rdata[15:0].
  - ACC1 reads sp_q+2 into rdata[31:16].
- ACCn access rules:
  - mem_req=1 with stable addr/we/wdata until mem_ack.
  - On ack, advance to ACC1 (32-bit, from ACC0) or to UPD.
  - mem_req drops in the cycle after ack.
- UPD:
  - sp_ctrl_o pulses for exactly one cycle: push16=100, push32=010, pop16=011, pop32=001. Otherwise 000.
  - Then go to RSP.
- RSP: rsp_valid=1 for one cycle with rsp_rdata, then IDLE. rsp_rdata holds until the next acceptance.
- Latency with zero-wait ack, counted from the accept edge:
  - 16-bit: UPD at +2, rsp_valid at +3.
  - 32-bit: UPD at +3, rsp_valid at +4.
  - Each wait cycle on mem_ack adds one cycle.
- Address arithmetic: 32-bit on sp_q, then truncated to ADDR_W.
  - sp_q=0 with push32 wraps to 0xFFFFF.
  - sp_q=0xFFFFF with pop wraps to 0 (without guard).
- cmd_valid outside IDLE is ignored; there is no queueing.

Optional Feature:
- STACK_GUARD_EN defined:
  - In IDLE, a pop with sp_i[ADDR_W-1:0] > STACK_TOP-1-size is an underflow (sp_i==STACK_TOP for 16-bit).
  - A push with sp_i-size < STACK_LIMIT is an overflow.
  - On either, the command is accepted, with no memory access and no SP pulse.
  - Next cycle: err_o=1 and rsp_valid=1 with rsp_rdata=0, then IDLE.
- Not defined: no checks, err_o constant 0, wrap-around as above.

Decomposition:
- Shared package stack_pkg:
  - sp_ctrl_t enum (SP_HOLD, SP_INC2, SP_DEC2, SP_INC1, SP_DEC1 = 000..100).
  - state enum.
  - STACK_TOP_DEFAULT constant.
- The SP register module also imports sp_ctrl_t.
- Single module; no sub-module needed.

Test Plan:
- Push16 0xBEEF, sp_i=0xFFFFF, ack same cycle -> write 0xBEEF @0xFFFFF; sp_ctrl_o=100 one cycle at +2; rsp_valid at +3.
- Push32 0x12345678, sp_i=0xFFFFF -> writes 0x1234 @0xFFFFF then 0x5678 @0xFFFFE; sp_ctrl_o=010; rsp_valid at +4.
- Pop32, sp_i=0xFFFFD, memory [0xFFFFE]=0x5678, [0xFFFFF]=0x1234 -> reads 0xFFFFE then 0xFFFFF; rsp_rdata=0x12345678; sp_ctrl_o=001.
- Pop16 with mem_ack delayed 3 cycles -> mem_req/addr stable 4 cycles; rsp_valid at +6; sp_ctrl_o=011 exactly once.
- Rst asserted during ACC1 of push32 -> next cycle IDLE, cmd_ready=1, no sp_ctrl_o pulse, no rsp_valid.
- STACK_GUARD_EN: pop16 at sp_i=0xFFFFF -> mem_req never asserted, err_o=rsp_valid=1 one cycle, sp_ctrl_o stays 000.
